// File: rtl/prim_ram_adapter_pkg.sv
`default_nettype none
// ============================================================================
// Module      : prim_ram_adapter_pkg
// Description : Shared types and constants for the RAM port adapter.
// Revision    : 1.0 - initial release
// ============================================================================
package prim_ram_adapter_pkg;

    localparam int unsigned c_err_cnt_w = 8;
    localparam int unsigned c_rsp_dw    = 32;

    typedef struct packed {
        logic [c_rsp_dw-1:0] rdata;
        logic [1:0]          rerror;
    } rsp_t;

    // Bits needed to index `value` entries; never less than one.
    function automatic int unsigned vbits(input int unsigned value);
        return (value <= 1) ? 1 : $clog2(value);
    endfunction

endpackage
`default_nettype wire

// File: rtl/prim_fifo_sync.sv
`default_nettype none
// ============================================================================
// Module      : prim_fifo_sync
// Description : Synchronous ring-buffer FIFO with optional fall-through.
// Revision    : 1.0 - initial release
// ============================================================================
module prim_fifo_sync
    import prim_ram_adapter_pkg::*;
#(
    parameter int unsigned Width  = 16,
    parameter bit          Pass   = 1'b0,
    parameter int unsigned Depth  = 4,
    localparam int unsigned DepthW = vbits(Depth + 1)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              wvalid_i,
    output logic              wready_o,
    input  logic [Width-1:0]  wdata_i,
    output logic              rvalid_o,
    input  logic              rready_i,
    output logic [Width-1:0]  rdata_o,
    output logic              full_o,
    output logic [DepthW-1:0] depth_o
);

    localparam int unsigned         c_ptr_w = vbits(Depth);
    localparam logic [c_ptr_w-1:0]  c_last  = c_ptr_w'(Depth - 1);
    localparam logic [DepthW-1:0]   c_full  = DepthW'(Depth);

    logic [Width-1:0]   r_mem [Depth];
    logic [c_ptr_w-1:0] r_wptr;
    logic [c_ptr_w-1:0] r_rptr;
    logic [DepthW-1:0]  r_depth;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_store;
    logic               w_unstore;

    assign w_empty = (r_depth == '0);
    assign full_o  = (r_depth == c_full);
    assign depth_o = r_depth;

    generate
        if (Pass) begin : g_pass
            assign rvalid_o = ~w_empty | wvalid_i;
            assign rdata_o  = w_empty ? wdata_i : r_mem[r_rptr];
        end else begin : g_nopass
            assign rvalid_o = ~w_empty;
            assign rdata_o  = r_mem[r_rptr];
        end
    endgenerate

    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign w_pop     = rvalid_o & rready_i;
    assign wready_o  = ~full_o | w_pop;
    assign w_push    = wvalid_i & wready_o;
    assign w_store   = w_push & ~(w_empty & w_pop);
    assign w_unstore = w_pop & ~w_empty;

    always_ff @(posedge clk_i) begin
        if (w_store) begin
            r_mem[r_wptr] <= wdata_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_depth <= '0;
        end else begin
            if (w_store) begin
                r_wptr <= (r_wptr == c_last) ? '0 : r_wptr + 1'b1;
            end
            if (w_unstore) begin
                r_rptr <= (r_rptr == c_last) ? '0 : r_rptr + 1'b1;
            end
            case ({w_store, w_unstore})
                2'b10:   r_depth <= r_depth + 1'b1;
                2'b01:   r_depth <= r_depth - 1'b1;
                default: r_depth <= r_depth;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/prim_ram_port_adapter.sv
`default_nettype none
// ============================================================================
// Module      : prim_ram_port_adapter
// Description : Credit-based host adapter for one latency-fixed RAM port.
// Revision    : 1.0 - initial release
// ============================================================================
module prim_ram_port_adapter
    import prim_ram_adapter_pkg::*;
#(
    parameter int unsigned  Depth     = 512,
    parameter int unsigned  Width     = 32,
    parameter int unsigned  RdLatency = 1,
    parameter int unsigned  RspDepth  = 4,
    localparam int unsigned Aw        = vbits(Depth)
) (
    input  logic                   clk_i,
    input  logic                   rst_i,
    input  logic                   req_valid_i,
    output logic                   req_ready_o,
    input  logic                   req_write_i,
    input  logic [Aw-1:0]          req_addr_i,
    input  logic [Width-1:0]       req_wdata_i,
    input  logic [Width-1:0]       req_wmask_i,
    output logic                   rsp_valid_o,
    input  logic                   rsp_ready_i,
    output logic [Width-1:0]       rsp_rdata_o,
    output logic [1:0]             rsp_rerror_o,
    output logic                   ram_req_o,
    output logic                   ram_write_o,
    output logic [Aw-1:0]          ram_addr_o,
    output logic [Width-1:0]       ram_wdata_o,
    output logic [Width-1:0]       ram_wmask_o,
    input  logic                   ram_rvalid_i,
    input  logic [Width-1:0]       ram_rdata_i,
    input  logic [1:0]             ram_rerror_i,
    output logic [c_err_cnt_w-1:0] err_cnt_o
);

    localparam int unsigned       c_cnt_w     = vbits(RspDepth + 1);
    localparam logic [c_cnt_w:0]  c_rsp_depth = (c_cnt_w + 1)'(RspDepth);

    generate
        if ((RdLatency < 1) || (RdLatency > 3)) begin : g_bad_latency
            $error("prim_ram_port_adapter: RdLatency must be 1..3");
        end
        if (RspDepth < RdLatency + 1) begin : g_bad_rsp_depth
            $error("prim_ram_port_adapter: RspDepth must be at least RdLatency + 1");
        end
    endgenerate

    logic [c_cnt_w-1:0]     r_outstanding;
    logic [c_cnt_w-1:0]     w_fifo_depth;
    logic [c_cnt_w:0]       w_used;
    logic                   w_accept;
    logic                   w_acc_read;
    logic                   w_rvalid_ok;
    logic                   w_fifo_wready;
    logic                   w_fifo_rvalid;
    logic                   w_fifo_full;
    logic                   w_push_fire;
    logic [Width+1:0]       w_fifo_rdata;
    logic [c_err_cnt_w-1:0] r_err_cnt;

    // Every read in flight reserves a buffer slot, so returns never overflow.
    assign w_used      = {1'b0, r_outstanding} + {1'b0, w_fifo_depth};
    assign req_ready_o = ~rst_i & (w_used < c_rsp_depth);
    assign w_accept    = req_valid_i & req_ready_o;
    assign w_acc_read  = w_accept & ~req_write_i;

    assign ram_req_o   = w_accept;
    assign ram_write_o = req_write_i;
    assign ram_addr_o  = req_addr_i;
    assign ram_wdata_o = req_wdata_i;
    assign ram_wmask_o = req_wmask_i;

    // Returns with nothing outstanding (e.g. from reads lost to reset) are dropped.
    assign w_rvalid_ok = ram_rvalid_i & (r_outstanding != '0);
    assign w_push_fire = w_rvalid_ok & w_fifo_wready;

    prim_fifo_sync #(
        .Width (Width + 2),
        .Pass  (1'b0),
        .Depth (RspDepth)
    ) u_rsp_fifo (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .wvalid_i (w_rvalid_ok),
        .wready_o (w_fifo_wready),
        .wdata_i  ({ram_rdata_i, ram_rerror_i}),
        .rvalid_o (w_fifo_rvalid),
        .rready_i (rsp_ready_i),
        .rdata_o  (w_fifo_rdata),
        .full_o   (w_fifo_full),
        .depth_o  (w_fifo_depth)
    );

    assign rsp_valid_o  = w_fifo_rvalid;
    assign rsp_rdata_o  = w_fifo_rvalid ? w_fifo_rdata[Width+1:2] : '0;
    assign rsp_rerror_o = w_fifo_rvalid ? w_fifo_rdata[1:0] : 2'b00;
    assign err_cnt_o    = r_err_cnt;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_outstanding <= '0;
        end else begin
            case ({w_acc_read, w_rvalid_ok})
                2'b10:   r_outstanding <= r_outstanding + 1'b1;
                2'b01:   r_outstanding <= r_outstanding - 1'b1;
                default: r_outstanding <= r_outstanding;
            endcase
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_err_cnt <= '0;
        end else if (w_push_fire && ram_rerror_i[1] && (r_err_cnt != '1)) begin
            r_err_cnt <= r_err_cnt + 1'b1;
        end
    end

    a_spurious_rvalid: assert property (@(posedge clk_i) disable iff (rst_i)
        ram_rvalid_i |-> (r_outstanding != '0))
        else $warning("ram_rvalid_i with no read outstanding, return dropped");

    a_push_when_full: assert property (@(posedge clk_i) disable iff (rst_i)
        (w_rvalid_ok && w_fifo_full) |-> rsp_ready_i)
        else $warning("response buffer full on RAM return, return dropped");

endmodule
`default_nettype wire

// File: tb/tb_prim_ram_port_adapter.sv
`default_nettype none
// ============================================================================
// Module      : tb_prim_ram_port_adapter
// Description : Directed vector bench with a behavioural one-cycle RAM model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_prim_ram_port_adapter;
    import prim_ram_adapter_pkg::*;

    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 9;

    logic            clk = 1'b0;
    logic            rst;
    logic            req_valid_i, req_ready_o, req_write_i;
    logic [AW-1:0]   req_addr_i;
    logic [31:0]     req_wdata_i, req_wmask_i;
    logic            rsp_valid_o, rsp_ready_i;
    logic [31:0]     rsp_rdata_o;
    logic [1:0]      rsp_rerror_o;
    logic            ram_req_o, ram_write_o;
    logic [AW-1:0]   ram_addr_o;
    logic [31:0]     ram_wdata_o, ram_wmask_o;
    logic            ram_rvalid_i;
    logic [31:0]     ram_rdata_i;
    logic [1:0]      ram_rerror_i;
    logic [7:0]      err_cnt_o;

    always #5 clk = ~clk;

    prim_ram_port_adapter #(
        .Depth(DEPTH), .Width(32), .RdLatency(1), .RspDepth(4)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_write_i(req_write_i),
        .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i), .req_wmask_i(req_wmask_i),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
        .rsp_rdata_o(rsp_rdata_o), .rsp_rerror_o(rsp_rerror_o),
        .ram_req_o(ram_req_o), .ram_write_o(ram_write_o), .ram_addr_o(ram_addr_o),
        .ram_wdata_o(ram_wdata_o), .ram_wmask_o(ram_wmask_o),
        .ram_rvalid_i(ram_rvalid_i), .ram_rdata_i(ram_rdata_i), .ram_rerror_i(ram_rerror_i),
        .err_cnt_o(err_cnt_o)
    );

    // RAM model: one-cycle read latency, writes land at the request cycle.
    logic [31:0] mem [DEPTH];
    logic        ram_mute = 1'b0;
    logic        ram_spur = 1'b0;
    logic [1:0]  rerr_inj = 2'b00;

    initial begin
        logic        pend, pend_spur;
        logic [31:0] pend_data;
        logic [1:0]  pend_err;
        ram_rvalid_i = 1'b0;
        ram_rdata_i  = '0;
        ram_rerror_i = 2'b00;
        forever begin
            @(negedge clk);
            if (ram_req_o && ram_write_o)
                mem[ram_addr_o] = (mem[ram_addr_o] & ~ram_wmask_o) | (ram_wdata_o & ram_wmask_o);
            pend      = ram_req_o && !ram_write_o && !ram_mute;
            pend_data = mem[ram_addr_o];
            pend_spur = ram_spur;
            pend_err  = rerr_inj;
            @(posedge clk);
            #1;
            ram_rvalid_i = pend | pend_spur;
            ram_rdata_i  = pend ? pend_data : (pend_spur ? 32'hBAD0_BAD0 : 32'h0);
            ram_rerror_i = (pend | pend_spur) ? pend_err : 2'b00;
        end
    end

    int checks   = 0;
    int failures = 0;
    logic [31:0] exp_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic w, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic rr);
        req_valid_i = v;
        req_write_i = w;
        req_addr_i  = a;
        req_wdata_i = d;
        req_wmask_i = 32'hFFFF_FFFF;
        rsp_ready_i = rr;
    endtask

    task automatic drain(input string name, input int n);
        int got = 0;
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        for (int k = 0; k < 20 && got < n; k++) begin
            @(negedge clk);
            if (rsp_valid_o) begin
                check(name, rsp_rdata_o, exp_q.pop_front());
                got++;
            end
            tick();
        end
        check({name, "_count"}, got, n);
    endtask

    task automatic stream_reads(input int n, input logic [1:0] err, output int got, output int bad);
        int issued = 0;
        got = 0;
        bad = 0;
        rerr_inj = err;
        for (int k = 0; k < 4 * n + 20 && got < n; k++) begin
            drive(issued < n, 1'b0, AW'(9'h100 + (issued % 64)), '0, 1'b1);
            @(negedge clk);
            if (req_valid_i && req_ready_o) issued++;
            if (rsp_valid_o) begin
                got++;
                if (rsp_rerror_o !== err) bad++;
            end
            tick();
        end
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        rerr_inj = 2'b00;
    endtask

    typedef struct {
        logic          v, w;
        logic [AW-1:0] addr;
        logic [31:0]   wdata, wmask;
        logic          rr;
        logic          exp_ready, exp_ram_req, exp_rvalid;
        rsp_t          exp_rsp;
    } vec_t;

    function automatic vec_t mk(input logic v, input logic w, input logic [AW-1:0] a,
                                input logic [31:0] d, input logic [31:0] m, input logic rr,
                                input logic er, input logic eq, input logic ev,
                                input logic [31:0] ed, input logic [1:0] ee);
        vec_t t;
        t.v = v; t.w = w; t.addr = a; t.wdata = d; t.wmask = m; t.rr = rr;
        t.exp_ready = er; t.exp_ram_req = eq; t.exp_rvalid = ev;
        t.exp_rsp.rdata = ed; t.exp_rsp.rerror = ee;
        return t;
    endfunction

    typedef struct {
        logic          w;
        logic [AW-1:0] a;
        logic [31:0]   d;
        logic          exp_ready;
    } op_t;

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t vecs[12];
        op_t  ops[9];
        int   acc, got, bad, gaps, pops, hi;
        logic [AW-1:0] a;

        for (int i = 0; i < DEPTH; i++) mem[i] = 32'h1000_0000 | i;

        //        v  w  addr     wdata          wmask          rr rdy req rv  rdata          rerr
        vecs[0]  = mk(1, 1, 9'h010, 32'hDEADBEEF, 32'hFFFFFFFF, 1, 1, 1, 0, 32'h0,         2'b00);
        vecs[1]  = mk(1, 0, 9'h010, 32'h0,        32'hFFFFFFFF, 1, 1, 1, 0, 32'h0,         2'b00);
        vecs[2]  = mk(0, 0, 9'h000, 32'h0,        32'hFFFFFFFF, 1, 1, 0, 0, 32'h0,         2'b00);
        vecs[3]  = mk(0, 0, 9'h000, 32'h0,        32'hFFFFFFFF, 1, 1, 0, 1, 32'hDEADBEEF,  2'b00);
        vecs[4]  = mk(0, 0, 9'h000, 32'h0,        32'hFFFFFFFF, 1, 1, 0, 0, 32'h0,         2'b00);
        vecs[5]  = mk(1, 1, 9'h020, 32'hFFFFFFFF, 32'h0000FFFF, 0, 1, 1, 0, 32'h0,         2'b00);
        vecs[6]  = mk(1, 0, 9'h020, 32'h0,        32'hFFFFFFFF, 0, 1, 1, 0, 32'h0,         2'b00);
        vecs[7]  = mk(1, 0, 9'h021, 32'h0,        32'hFFFFFFFF, 0, 1, 1, 0, 32'h0,         2'b00);
        vecs[8]  = mk(0, 0, 9'h000, 32'h0,        32'hFFFFFFFF, 0, 1, 0, 1, 32'h1000FFFF,  2'b00);
        vecs[9]  = mk(0, 0, 9'h000, 32'h0,        32'hFFFFFFFF, 1, 1, 0, 1, 32'h1000FFFF,  2'b00);
        vecs[10] = mk(0, 0, 9'h000, 32'h0,        32'hFFFFFFFF, 1, 1, 0, 1, 32'h10000021,  2'b00);
        vecs[11] = mk(0, 0, 9'h000, 32'h0,        32'hFFFFFFFF, 1, 1, 0, 0, 32'h0,         2'b00);

        // Reset: outputs quiet even with a request pending.
        rst = 1'b1;
        drive(1'b1, 1'b0, 9'h005, '0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        @(negedge clk);
        check("rst_ready", req_ready_o, 1'b0);
        check("rst_ram_req", ram_req_o, 1'b0);
        check("rst_rsp_valid", rsp_valid_o, 1'b0);
        check("rst_err_cnt", err_cnt_o, 8'd0);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_ready", req_ready_o, 1'b1);
        tick();

        for (int i = 0; i < 12; i++) begin
            drive(vecs[i].v, vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].rr);
            req_wmask_i = vecs[i].wmask;
            @(negedge clk);
            check($sformatf("vec%0d_ready", i), req_ready_o, vecs[i].exp_ready);
            check($sformatf("vec%0d_ram_req", i), ram_req_o, vecs[i].exp_ram_req);
            check($sformatf("vec%0d_rsp_valid", i), rsp_valid_o, vecs[i].exp_rvalid);
            check($sformatf("vec%0d_rsp", i), {rsp_rdata_o, rsp_rerror_o}, vecs[i].exp_rsp);
            if (vecs[i].exp_ram_req) begin
                check($sformatf("vec%0d_ram_fields", i),
                      {ram_write_o, ram_addr_o, ram_wdata_o, ram_wmask_o},
                      {vecs[i].w, vecs[i].addr, vecs[i].wdata, vecs[i].wmask});
            end
            tick();
        end

        // Credit exhaustion with the response side stalled.
        acc = 0;
        a = 9'h040;
        for (int k = 0; k < 8; k++) begin
            drive(1'b1, 1'b0, a, '0, 1'b0);
            @(negedge clk);
            if (req_ready_o) begin
                acc++;
                a = a + 1'b1;
            end
            tick();
        end
        check("credit_accepts", acc, 4);
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        check("credit_ready_low", req_ready_o, 1'b0);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        @(negedge clk);
        check("credit_pop_data", {rsp_valid_o, rsp_rdata_o}, {1'b1, 32'h10000040});
        tick();
        drive(1'b1, 1'b0, 9'h044, '0, 1'b0);
        @(negedge clk);
        check("credit_ready_after_pop", {req_ready_o, ram_req_o}, 2'b11);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b0);
        @(negedge clk);
        check("credit_ready_low2", req_ready_o, 1'b0);
        tick();
        exp_q = '{32'h10000041, 32'h10000042, 32'h10000043, 32'h10000044};
        drain("credit_drain", 4);

        // Writes never consume credit; once reads exhaust it, writes stall too.
        ops[0] = '{1'b1, 9'h050, 32'hAAAA0050, 1'b1};
        ops[1] = '{1'b0, 9'h050, 32'h0,        1'b1};
        ops[2] = '{1'b1, 9'h051, 32'hBBBB0051, 1'b1};
        ops[3] = '{1'b0, 9'h051, 32'h0,        1'b1};
        ops[4] = '{1'b1, 9'h052, 32'hCCCC0052, 1'b1};
        ops[5] = '{1'b1, 9'h053, 32'hDDDD0053, 1'b1};
        ops[6] = '{1'b0, 9'h060, 32'h0,        1'b1};
        ops[7] = '{1'b0, 9'h061, 32'h0,        1'b1};
        ops[8] = '{1'b1, 9'h054, 32'hEEEE0054, 1'b0};
        for (int i = 0; i < 9; i++) begin
            drive(1'b1, ops[i].w, ops[i].a, ops[i].d, 1'b0);
            @(negedge clk);
            check($sformatf("mix%0d_ready", i), req_ready_o, ops[i].exp_ready);
            tick();
        end
        exp_q = '{32'hAAAA0050, 32'hBBBB0051, 32'h10000060, 32'h10000061};
        drain("mix_drain", 4);

        // Fill, then stream with push and pop in the same cycles.
        exp_q = {};
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, AW'(9'h080 + k), '0, 1'b0);
            exp_q.push_back(32'h10000080 + k);
            @(negedge clk);
            check($sformatf("fill%0d_ready", k), req_ready_o, 1'b1);
            tick();
        end
        gaps = 0;
        pops = 0;
        a = 9'h084;
        for (int k = 0; k < 12; k++) begin
            drive(1'b1, 1'b0, a, '0, 1'b1);
            @(negedge clk);
            if (rsp_valid_o) begin
                check("stream_order", rsp_rdata_o, exp_q.pop_front());
                pops++;
            end else begin
                gaps++;
            end
            if (req_ready_o) begin
                exp_q.push_back(32'h10000000 | 32'(a));
                a = a + 1'b1;
            end
            tick();
        end
        check("stream_gaps", gaps, 0);
        check("stream_pops", pops, 12);
        drain("stream_drain", exp_q.size());

        // Correctable errors pass through without counting; uncorrectable saturate.
        stream_reads(3, 2'b01, got, bad);
        check("corr_count", got, 3);
        check("corr_rerror", bad, 0);
        check("corr_err_cnt", err_cnt_o, 8'd0);
        stream_reads(200, 2'b10, got, bad);
        check("uncorr200_count", got, 200);
        check("uncorr200_err_cnt", err_cnt_o, 8'd200);
        stream_reads(100, 2'b10, got, bad);
        check("uncorr300_count", got, 100);
        check("uncorr300_rerror", bad, 0);
        check("uncorr300_err_cnt", err_cnt_o, 8'd255);

        // Reset with reads in flight; a late RAM return must be discarded.
        ram_mute = 1'b1;
        for (int k = 0; k < 3; k++) begin
            drive(1'b1, 1'b0, AW'(9'h0A0 + k), '0, 1'b0);
            @(negedge clk);
            check($sformatf("inflight%0d_ready", k), req_ready_o, 1'b1);
            tick();
        end
        drive(1'b1, 1'b0, 9'h0A3, '0, 1'b0);
        rst = 1'b1;
        @(negedge clk);
        check("midrst_quiet", {req_ready_o, ram_req_o, rsp_valid_o}, 3'b000);
        check("midrst_err_cnt", err_cnt_o, 8'd0);
        tick();
        drive(1'b0, 1'b0, '0, '0, 1'b1);
        tick();
        rst = 1'b0;
        ram_mute = 1'b0;
        ram_spur = 1'b1;
        @(negedge clk);
        check("midrst_release_ready", req_ready_o, 1'b1);
        tick();
        ram_spur = 1'b0;
        hi = 0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            if (rsp_valid_o) hi++;
            tick();
        end
        check("spurious_no_rsp", hi, 0);
        @(negedge clk);
        check("spurious_ready", req_ready_o, 1'b1);
        tick();
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 1'b0, 9'h010, '0, 1'b0);
            @(negedge clk);
            if (req_ready_o) acc++;
            tick();
        end
        check("post_rst_full_credit", acc, 4);
        exp_q = '{32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF, 32'hDEADBEEF};
        drain("post_rst_drain", 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
